multi_adder_tree_acc: RTL

Next-generation parallel adder array for the conv datapath.
- NUM_ADDERS independent lanes. Each lane sums INPUTS_PER_ADDER signed products through a registered binary tree.
- Each lane accumulates partial sums over multiple input beats (input-channel tiling), adds a per-lane bias, and saturates to the output width.
- Valid/ready handshake on both sides. Sits between the multiplier array and the activation/requant stage.

---
 rtl/mac_pkg.sv | 42 ++++
 rtl/multi_adder_tree_acc_if.sv | 28 ++
 rtl/adder_tree_pipe.sv | 39 +++
 rtl/multi_adder_tree_acc.sv | 114 +++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared helpers for the adder-tree accumulator: tree sizing and signed saturation.
package mac_pkg;

    // Ceiling log2 of a positive count (minimum 1 level for a count of 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Number of registered adder levels needed for n operands.
    function automatic int tree_depth(input int n);
        return clog2(n);
    endfunction

    // Width that holds the sum of n operands of dw bits without overflow.
    function automatic int tree_width(input int dw, input int n);
        return dw + clog2(n);
    endfunction

    // Clip a signed value into the range of an ow-bit signed number.
    function automatic longint sat_val(input longint v, input int ow);
        longint hi;
        longint lo;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // True when sat_val would have to clip v.
    function automatic logic sat_hit(input longint v, input int ow);
        longint hi;
        longint lo;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/multi_adder_tree_acc_if.sv
// Beat-in / result-out handshake bundle for the adder-tree accumulator.
interface multi_adder_tree_acc_if #(
    parameter int DATA_WIDTH       = 14,
    parameter int NUM_ADDERS       = 16,
    parameter int INPUTS_PER_ADDER = 27,
    parameter int OUT_WIDTH        = 16
);
    logic                                               in_valid;
    logic                                               in_ready;
    logic                                               in_first;
    logic                                               in_last;
    logic [NUM_ADDERS*INPUTS_PER_ADDER*DATA_WIDTH-1:0]  input_data;
    logic [NUM_ADDERS*OUT_WIDTH-1:0]                    bias;
    logic                                               out_valid;
    logic                                               out_ready;
    logic [NUM_ADDERS*OUT_WIDTH-1:0]                    adder_outputs;
    logic [NUM_ADDERS-1:0]                              sat_flags;

    modport master (
        output in_valid, in_first, in_last, input_data, bias, out_ready,
        input  in_ready, out_valid, adder_outputs, sat_flags
    );

    modport slave (
        input  in_valid, in_first, in_last, input_data, bias, out_ready,
        output in_ready, out_valid, adder_outputs, sat_flags
    );
endinterface

// File: rtl/adder_tree_pipe.sv
// One lane's registered binary adder tree. Operands are zero-padded up to a
// power of two and held in a heap-ordered node array: node n sums nodes
// 2n+1 and 2n+2, leaves occupy the top half, node 0 is the root.
module adder_tree_pipe
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int INPUTS     = 27
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                i_en,
    input  logic [INPUTS*DATA_WIDTH-1:0]                        i_data,
    output logic signed [tree_width(DATA_WIDTH, INPUTS)-1:0]    o_sum
);
    localparam int DEPTH  = tree_depth(INPUTS);
    localparam int WIDTH  = tree_width(DATA_WIDTH, INPUTS);
    localparam int LEAVES = 1 << DEPTH;
    localparam int NODES  = 2 * LEAVES - 1;

    logic [LEAVES*DATA_WIDTH-1:0] w_pad;
    logic signed [WIDTH-1:0]      r_node [NODES];

    assign w_pad = (LEAVES*DATA_WIDTH)'(i_data);

    // Register sign-extended leaves and one adder level per node row; all hold when disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NODES; n++) r_node[n] <= '0;
        end else if (i_en) begin
            for (int n = 0; n < LEAVES - 1; n++)
                r_node[n] <= r_node[2*n+1] + r_node[2*n+2];
            for (int j = 0; j < LEAVES; j++)
                r_node[LEAVES-1+j] <= WIDTH'($signed(w_pad[j*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    assign o_sum = r_node[0];
endmodule

// File: rtl/multi_adder_tree_acc.sv
// Parallel adder-tree lanes with per-group accumulation, bias and output saturation.
// Pipeline: leaf regs + DEPTH adder levels -> accumulate -> saturate/output.
// A single enable (no result pending, or result being taken) stalls every stage.
module multi_adder_tree_acc
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH       = 14,
    parameter int NUM_ADDERS       = 16,
    parameter int INPUTS_PER_ADDER = 27,
    parameter int ACC_WIDTH        = 24,
    parameter int OUT_WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    multi_adder_tree_acc_if.slave   bus
);
    localparam int TREE_DEPTH = tree_depth(INPUTS_PER_ADDER);
    localparam int TREE_WIDTH = tree_width(DATA_WIDTH, INPUTS_PER_ADDER);
    localparam int LANE_W     = INPUTS_PER_ADDER * DATA_WIDTH;
    localparam int BIAS_W     = NUM_ADDERS * OUT_WIDTH;

    logic                           w_en;
    logic [TREE_DEPTH:0]            r_sv;
    logic [TREE_DEPTH:0]            r_sf;
    logic [TREE_DEPTH:0]            r_sl;
    logic [BIAS_W-1:0]              r_sb [0:TREE_DEPTH];
    logic signed [TREE_WIDTH-1:0]   w_tree [NUM_ADDERS];
    logic signed [ACC_WIDTH-1:0]    w_acc_next [NUM_ADDERS];
    logic signed [ACC_WIDTH-1:0]    r_acc [NUM_ADDERS];
    logic                           r_av;
    logic                           r_al;
    logic                           r_out_valid;
    logic [BIAS_W-1:0]              r_out;
    logic [NUM_ADDERS-1:0]          r_sat;

    assign w_en              = !r_out_valid || bus.out_ready;
    assign bus.in_ready      = w_en;
    assign bus.out_valid     = r_out_valid;
    assign bus.adder_outputs = r_out;
    assign bus.sat_flags     = r_sat;

    for (genvar g = 0; g < NUM_ADDERS; g++) begin : g_lane
        adder_tree_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .INPUTS     (INPUTS_PER_ADDER)
        ) u_tree (
            .clk    (clk),
            .reset  (reset),
            .i_en   (w_en),
            .i_data (bus.input_data[g*LANE_W +: LANE_W]),
            .o_sum  (w_tree[g])
        );
    end

    // Delay valid/first/last/bias in lock-step with the tree so they arrive with the sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sv <= '0;
            r_sf <= '0;
            r_sl <= '0;
            for (int k = 0; k <= TREE_DEPTH; k++) r_sb[k] <= '0;
        end else if (w_en) begin
            r_sv    <= {r_sv[TREE_DEPTH-1:0], bus.in_valid};
            r_sf    <= {r_sf[TREE_DEPTH-1:0], bus.in_first};
            r_sl    <= {r_sl[TREE_DEPTH-1:0], bus.in_last};
            r_sb[0] <= bus.bias;
            for (int k = 1; k <= TREE_DEPTH; k++) r_sb[k] <= r_sb[k-1];
        end
    end

    // Next accumulator value: a first beat restarts from the bias, otherwise adds on.
    always_comb begin
        for (int i = 0; i < NUM_ADDERS; i++) begin
            w_acc_next[i] = (r_sf[TREE_DEPTH]
                             ? ACC_WIDTH'($signed(r_sb[TREE_DEPTH][i*OUT_WIDTH +: OUT_WIDTH]))
                             : r_acc[i])
                            + ACC_WIDTH'(w_tree[i]);
        end
    end

    // Accumulate stage: only valid beats touch the accumulators, bubbles leave them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_av <= 1'b0;
            r_al <= 1'b0;
            for (int i = 0; i < NUM_ADDERS; i++) r_acc[i] <= '0;
        end else if (w_en) begin
            r_av <= r_sv[TREE_DEPTH];
            r_al <= r_sl[TREE_DEPTH];
            if (r_sv[TREE_DEPTH]) begin
                for (int i = 0; i < NUM_ADDERS; i++) r_acc[i] <= w_acc_next[i];
            end
        end
    end

    // Output stage: publish the saturated group total once the last beat has been accumulated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_sat       <= '0;
        end else if (w_en) begin
            if (r_av && r_al) begin
                r_out_valid <= 1'b1;
                for (int i = 0; i < NUM_ADDERS; i++) begin
                    r_out[i*OUT_WIDTH +: OUT_WIDTH] <= OUT_WIDTH'(sat_val(longint'(r_acc[i]), OUT_WIDTH));
                    r_sat[i]                        <= sat_hit(longint'(r_acc[i]), OUT_WIDTH);
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
